// File: rtl/pac_flash_writer.sv
// rtl/pac_flash_writer.sv - copies a PAC image from SD-RAM into SPI flash (sector erase, then page program)
module pac_flash_writer #(
    parameter logic [23:0] SRC_ADDR = 24'h77_E000,
    parameter logic [23:0] DST_ADDR = 24'h1F_0000,
    parameter logic [23:0] SIZE     = 24'h00_2000,
    parameter logic [23:0] TIMEOUT  = 24'hFF_FFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [23:0] RAM_ADDR,
    output logic        RAM_REQ,
    input  logic        RAM_ACK,
    input  logic [7:0]  RAM_RDATA,
    output logic        FLASH_REQ,
    output logic        FLASH_OP,
    output logic [23:0] FLASH_ADDR,
    input  logic        FLASH_ACK,
    output logic [7:0]  FLASH_WDATA,
    output logic        FLASH_WVALID,
    input  logic        FLASH_WREADY,
    input  logic        FLASH_DONE
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ERASE_REQ  = 3'd1;
    localparam logic [2:0] S_ERASE_WAIT = 3'd2;
    localparam logic [2:0] S_PROG_REQ   = 3'd3;
    localparam logic [2:0] S_RAM_RD     = 3'd4;
    localparam logic [2:0] S_FL_WR      = 3'd5;
    localparam logic [2:0] S_PROG_WAIT  = 3'd6;
    localparam logic [2:0] S_FINISH     = 3'd7;

    localparam logic [23:0] SECTOR_BYTES = 24'd4096;

    logic [2:0]  state_q, state_d;
    logic [23:0] ofs_q, ofs_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        error_q, error_d;

    logic        timed_state;
    logic        timeout_hit;
    logic [23:0] ofs_sector;
    logic [23:0] ofs_byte;

    // Only the flash handshake states are guarded; RAM and write-data stalls may last forever.
    assign timed_state = (state_q == S_ERASE_REQ) || (state_q == S_ERASE_WAIT) ||
                         (state_q == S_PROG_REQ)  || (state_q == S_PROG_WAIT);
    assign timeout_hit = (cnt_q == (TIMEOUT - 24'd1));
    assign ofs_sector  = ofs_q + SECTOR_BYTES;
    assign ofs_byte    = ofs_q + 24'd1;

    // Next-state, offset, write-data latch and timeout counter.
    always_comb begin
        state_d = state_q;
        ofs_d   = ofs_q;
        wdata_d = wdata_q;
        error_d = 1'b0;
        cnt_d   = cnt_q + 24'd1;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ofs_d   = 24'd0;
                    state_d = S_ERASE_REQ;
                end
            end
            S_ERASE_REQ: begin
                if (FLASH_ACK) begin
                    state_d = S_ERASE_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
            end
            S_ERASE_WAIT: begin
                if (FLASH_DONE) begin
                    if (ofs_sector == SIZE) begin
                        ofs_d   = 24'd0;
                        state_d = S_PROG_REQ;
                    end else begin
                        ofs_d   = ofs_sector;
                        state_d = S_ERASE_REQ;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
            end
            S_PROG_REQ: begin
                if (FLASH_ACK) begin
                    state_d = S_RAM_RD;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
            end
            S_RAM_RD: begin
                if (RAM_ACK) begin
                    wdata_d = RAM_RDATA;
                    state_d = S_FL_WR;
                end
            end
            S_FL_WR: begin
                if (FLASH_WREADY) begin
                    ofs_d   = ofs_byte;
                    state_d = (ofs_byte[7:0] == 8'd0) ? S_PROG_WAIT : S_RAM_RD;
                end
            end
            S_PROG_WAIT: begin
                if (FLASH_DONE) begin
                    state_d = (ofs_q == SIZE) ? S_FINISH : S_PROG_REQ;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The counter restarts on every state change and idles at zero elsewhere.
        if (!timed_state || (state_d != state_q)) begin
            cnt_d = 24'd0;
        end
    end

    // State registers with synchronous reset; reset abandons any partial page.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ofs_q   <= 24'd0;
            cnt_q   <= 24'd0;
            wdata_q <= 8'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ofs_q   <= ofs_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    // Requests are pure decodes of the state so each drops the cycle after its handshake.
    assign BUSY         = (state_q != S_IDLE);
    assign DONE         = (state_q == S_FINISH);
    assign ERROR        = error_q;
    assign RAM_REQ      = (state_q == S_RAM_RD);
    assign RAM_ADDR     = RAM_REQ ? (SRC_ADDR + ofs_q) : 24'd0;
    assign FLASH_REQ    = (state_q == S_ERASE_REQ) || (state_q == S_PROG_REQ);
    assign FLASH_OP     = (state_q == S_PROG_REQ);
    assign FLASH_ADDR   = FLASH_REQ ? (DST_ADDR + ofs_q) : 24'd0;
    assign FLASH_WVALID = (state_q == S_FL_WR);
    assign FLASH_WDATA  = wdata_q;

endmodule

// File: tb/tb_pac_flash_writer.sv
// tb/tb_pac_flash_writer.sv - directed bench for pac_flash_writer with ideal RAM and flash responders
module tb_pac_flash_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    int   sel;
    logic clr;
    logic stall_en;
    logic block2;

    logic        busy_w [3];
    logic        done_w [3];
    logic        err_w [3];
    logic        ram_req_w [3];
    logic        fl_req_w [3];
    logic        fl_op_w [3];
    logic        wvalid_w [3];
    logic [23:0] ram_addr_w [3];
    logic [23:0] fl_addr_w [3];
    logic [7:0]  wdata_w [3];
    logic        start_w [3];
    logic        ram_ack_w [3];
    logic        fl_ack_w [3];
    logic        wready_w [3];
    logic        fl_done_w [3];

    logic       ram_ack_q;
    logic [7:0] ram_rdata_q;
    logic       fl_ack_q;
    logic       wready_q;
    logic       fl_done_q;

    for (genvar g = 0; g < 3; g++) begin : g_route
        assign start_w[g]   = (sel == g) && start;
        assign ram_ack_w[g] = (sel == g) && ram_ack_q;
        assign fl_ack_w[g]  = (sel == g) && fl_ack_q;
        assign wready_w[g]  = (sel == g) && wready_q;
        assign fl_done_w[g] = (sel == g) && fl_done_q;
    end

    pac_flash_writer u_def (
        .CLK(clk), .RESET(rst), .START(start_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .ERROR(err_w[0]),
        .RAM_ADDR(ram_addr_w[0]), .RAM_REQ(ram_req_w[0]), .RAM_ACK(ram_ack_w[0]), .RAM_RDATA(ram_rdata_q),
        .FLASH_REQ(fl_req_w[0]), .FLASH_OP(fl_op_w[0]), .FLASH_ADDR(fl_addr_w[0]), .FLASH_ACK(fl_ack_w[0]),
        .FLASH_WDATA(wdata_w[0]), .FLASH_WVALID(wvalid_w[0]), .FLASH_WREADY(wready_w[0]), .FLASH_DONE(fl_done_w[0])
    );

    pac_flash_writer #(.TIMEOUT(24'd100)) u_to (
        .CLK(clk), .RESET(rst), .START(start_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .ERROR(err_w[1]),
        .RAM_ADDR(ram_addr_w[1]), .RAM_REQ(ram_req_w[1]), .RAM_ACK(ram_ack_w[1]), .RAM_RDATA(ram_rdata_q),
        .FLASH_REQ(fl_req_w[1]), .FLASH_OP(fl_op_w[1]), .FLASH_ADDR(fl_addr_w[1]), .FLASH_ACK(fl_ack_w[1]),
        .FLASH_WDATA(wdata_w[1]), .FLASH_WVALID(wvalid_w[1]), .FLASH_WREADY(wready_w[1]), .FLASH_DONE(fl_done_w[1])
    );

    pac_flash_writer #(.DST_ADDR(24'hFF_F000), .SIZE(24'h00_1000)) u_sm (
        .CLK(clk), .RESET(rst), .START(start_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]), .ERROR(err_w[2]),
        .RAM_ADDR(ram_addr_w[2]), .RAM_REQ(ram_req_w[2]), .RAM_ACK(ram_ack_w[2]), .RAM_RDATA(ram_rdata_q),
        .FLASH_REQ(fl_req_w[2]), .FLASH_OP(fl_op_w[2]), .FLASH_ADDR(fl_addr_w[2]), .FLASH_ACK(fl_ack_w[2]),
        .FLASH_WDATA(wdata_w[2]), .FLASH_WVALID(wvalid_w[2]), .FLASH_WREADY(wready_w[2]), .FLASH_DONE(fl_done_w[2])
    );

    logic        m_busy, m_done, m_err, m_ram_req, m_fl_req, m_fl_op, m_wvalid;
    logic [23:0] m_ram_addr, m_fl_addr;
    logic [7:0]  m_wdata;
    assign m_busy     = busy_w[sel];
    assign m_done     = done_w[sel];
    assign m_err      = err_w[sel];
    assign m_ram_req  = ram_req_w[sel];
    assign m_fl_req   = fl_req_w[sel];
    assign m_fl_op    = fl_op_w[sel];
    assign m_wvalid   = wvalid_w[sel];
    assign m_ram_addr = ram_addr_w[sel];
    assign m_fl_addr  = fl_addr_w[sel];
    assign m_wdata    = wdata_w[sel];

    function automatic logic [7:0] fdat(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    int          msize;
    assign msize = (sel == 2) ? 4096 : 8192;
    localparam logic [23:0] SRC = 24'h77_E000;

    logic [23:0] erase_q [$];
    logic [23:0] prog_q [$];
    int n_rd, wr_cnt, pg_bytes, n_done, n_err, busy_cyc;
    int ram_bad, wr_bad, stall_bad, stall_n;
    logic [7:0] stall_data;

    // Ideal responders: every request is acknowledged one cycle after it appears.
    always @(posedge clk) begin
        if (clr) begin
            ram_ack_q <= 1'b0; ram_rdata_q <= 8'd0; fl_ack_q <= 1'b0; wready_q <= 1'b0; fl_done_q <= 1'b0;
            n_rd <= 0; wr_cnt <= 0; pg_bytes <= 0; n_done <= 0; n_err <= 0; busy_cyc <= 0;
            ram_bad <= 0; wr_bad <= 0; stall_bad <= 0; stall_n <= 0; stall_data <= 8'd0;
            erase_q.delete();
            prog_q.delete();
        end else begin
            ram_ack_q   <= m_ram_req && !ram_ack_q;
            ram_rdata_q <= fdat(m_ram_addr);
            if (m_ram_req && ram_ack_q) begin
                n_rd <= n_rd + 1;
                if (m_ram_addr !== SRC + 24'(n_rd % msize)) ram_bad <= ram_bad + 1;
            end
            fl_ack_q  <= m_fl_req && !fl_ack_q;
            fl_done_q <= (m_fl_req && fl_ack_q && !m_fl_op && !(block2 && erase_q.size() == 1)) ||
                         (m_wvalid && wready_q && pg_bytes == 255);
            if (m_fl_req && fl_ack_q) begin
                if (!m_fl_op) begin
                    erase_q.push_back(m_fl_addr);
                end else begin
                    prog_q.push_back(m_fl_addr);
                    pg_bytes <= 0;
                end
            end
            if (m_wvalid && !wready_q) begin
                if (stall_en && wr_cnt == 127 && stall_n < 5) begin
                    stall_n <= stall_n + 1;
                    if (stall_n == 0) stall_data <= m_wdata;
                    else if (m_wdata !== stall_data) stall_bad <= stall_bad + 1;
                end else begin
                    wready_q <= 1'b1;
                end
            end else begin
                wready_q <= 1'b0;
            end
            if (stall_n > 0 && stall_n < 5 && !m_wvalid) stall_bad <= stall_bad + 1;
            if (m_wvalid && wready_q) begin
                wr_cnt   <= wr_cnt + 1;
                pg_bytes <= pg_bytes + 1;
                if (m_wdata !== fdat(SRC + 24'(wr_cnt % msize))) wr_bad <= wr_bad + 1;
                if (stall_en && wr_cnt == 127 && m_wdata !== stall_data) stall_bad <= stall_bad + 1;
            end
            if (m_done) n_done <= n_done + 1;
            if (m_err) n_err <= n_err + 1;
            if (m_busy) busy_cyc <= busy_cyc + 1;
        end
    end

    int checks;
    int errors;
    int held;

    task automatic model_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [62:0] v;
        rst = 1'b1; start = 1'b0; sel = 0; clr = 1'b1; stall_en = 1'b0; block2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            v = {busy_w[k], done_w[k], err_w[k], ram_req_w[k], fl_req_w[k], fl_op_w[k], wvalid_w[k],
                 ram_addr_w[k], fl_addr_w[k], wdata_w[k]};
            checks++;
            if (v !== 63'd0) begin errors++; $display("FAIL reset_outputs inst %0d got %h want 0", k, v); end
        end
        rst = 1'b0; clr = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy_w[0]); end
    endtask

    task automatic test_full_save();
        int c;
        sel = 0; model_clear(); stall_en = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        c = 0;
        while (done_w[0] !== 1'b1 && c < 40000) begin @(negedge clk); c++; end
        checks++;
        if (done_w[0] !== 1'b1) begin errors++; $display("FAIL full_done_wait got %b want 1", done_w[0]); end
        repeat (3) @(negedge clk);
        stall_en = 1'b0;
        checks++; if (n_done !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", n_done); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL full_error_count got %0d want 0", n_err); end
        checks++; if (erase_q.size() !== 2) begin errors++; $display("FAIL full_erase_count got %0d want 2", erase_q.size()); end
        checks++; if (erase_q[0] !== 24'h1F_0000) begin errors++; $display("FAIL full_erase0 got %h want 1f0000", erase_q[0]); end
        checks++; if (erase_q[1] !== 24'h1F_1000) begin errors++; $display("FAIL full_erase1 got %h want 1f1000", erase_q[1]); end
        checks++; if (prog_q.size() !== 32) begin errors++; $display("FAIL full_prog_count got %0d want 32", prog_q.size()); end
        for (int i = 0; i < prog_q.size(); i++) begin
            checks++;
            if (prog_q[i] !== 24'h1F_0000 + 24'(i * 256)) begin
                errors++; $display("FAIL full_prog_addr %0d got %h want %h", i, prog_q[i], 24'h1F_0000 + 24'(i * 256));
            end
        end
        checks++; if (n_rd !== 8192) begin errors++; $display("FAIL full_ram_reads got %0d want 8192", n_rd); end
        checks++; if (ram_bad !== 0) begin errors++; $display("FAIL full_ram_order got %0d want 0", ram_bad); end
        checks++; if (wr_cnt !== 8192) begin errors++; $display("FAIL full_bytes_written got %0d want 8192", wr_cnt); end
        checks++; if (wr_bad !== 0) begin errors++; $display("FAIL full_byte_data got %0d want 0", wr_bad); end
        checks++; if (stall_n !== 5) begin errors++; $display("FAIL stall_cycles got %0d want 5", stall_n); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stall_bad); end
        checks++; if (busy_cyc !== 32876) begin errors++; $display("FAIL full_busy_cycles got %0d want 32876", busy_cyc); end
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL full_busy_end got %b want 0", busy_w[0]); end
    endtask

    task automatic test_reset_mid_page();
        int c;
        sel = 0; model_clear();
        start = 1'b1; @(negedge clk); start = 1'b0;
        c = 0;
        while (!(prog_q.size() == 6 && wvalid_w[0] === 1'b1) && c < 8000) begin @(negedge clk); c++; end
        checks++;
        if (wvalid_w[0] !== 1'b1) begin errors++; $display("FAIL midpage_reach got %b want 1", wvalid_w[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ram_req_w[0], fl_req_w[0], wvalid_w[0]} !== 3'b000) begin
            errors++; $display("FAIL midpage_requests got %b want 000", {ram_req_w[0], fl_req_w[0], wvalid_w[0]});
        end
        checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL midpage_busy got %b want 0", busy_w[0]); end
        rst = 1'b0;
        model_clear();
        start = 1'b1; @(negedge clk); start = 1'b0;
        c = 0;
        while (fl_req_w[0] !== 1'b1 && c < 10) begin @(negedge clk); c++; end
        checks++;
        if ({fl_req_w[0], fl_op_w[0], fl_addr_w[0]} !== {2'b10, 24'h1F_0000}) begin
            errors++; $display("FAIL restart_erase got req=%b op=%b addr=%h want req=1 op=0 addr=1f0000",
                               fl_req_w[0], fl_op_w[0], fl_addr_w[0]);
        end
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_timeout();
        int acks, c, n;
        sel = 1; block2 = 1'b1; model_clear();
        start = 1'b1; @(negedge clk); start = 1'b0;
        acks = 0; c = 0;
        while (acks < 2 && c < 500) begin
            @(negedge clk); c++;
            if (m_fl_req && fl_ack_q && !m_fl_op) acks++;
        end
        checks++; if (acks !== 2) begin errors++; $display("FAIL timeout_erase_acks got %0d want 2", acks); end
        n = 0; c = 0;
        while (c < 300) begin
            @(negedge clk); c++;
            if (err_w[1] === 1'b1) break;
            n++;
        end
        checks++; if (n !== 100) begin errors++; $display("FAIL timeout_latency got %0d want 100", n); end
        checks++; if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy_w[1]); end
        checks++; if (fl_req_w[1] !== 1'b0) begin errors++; $display("FAIL timeout_flash_req got %b want 0", fl_req_w[1]); end
        @(negedge clk);
        checks++; if (err_w[1] !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %b want 0", err_w[1]); end
        repeat (3) @(negedge clk);
        checks++; if (n_err !== 1) begin errors++; $display("FAIL timeout_error_count got %0d want 1", n_err); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL timeout_no_done got %0d want 0", n_done); end
        checks++; if (prog_q.size() !== 0) begin errors++; $display("FAIL timeout_no_program got %0d want 0", prog_q.size()); end
        block2 = 1'b0;
    endtask

    task automatic test_small_size();
        sel = 2; model_clear();
        start = 1'b1; held = 0;
        while (done_w[2] !== 1'b1 && held < 20000) begin @(negedge clk); held++; end
        checks++; if (done_w[2] !== 1'b1) begin errors++; $display("FAIL small_done_wait got %b want 1", done_w[2]); end
        checks++; if (erase_q.size() !== 1) begin errors++; $display("FAIL small_erase_count got %0d want 1", erase_q.size()); end
        checks++; if (erase_q[0] !== 24'hFF_F000) begin errors++; $display("FAIL small_erase_addr got %h want fff000", erase_q[0]); end
        checks++; if (prog_q.size() !== 16) begin errors++; $display("FAIL small_prog_count got %0d want 16", prog_q.size()); end
        for (int i = 0; i < prog_q.size(); i++) begin
            checks++;
            if (prog_q[i] !== 24'hFF_F000 + 24'(i * 256)) begin
                errors++; $display("FAIL small_prog_addr %0d got %h want %h", i, prog_q[i], 24'hFF_F000 + 24'(i * 256));
            end
        end
        checks++; if (n_rd !== 4096) begin errors++; $display("FAIL small_ram_reads got %0d want 4096", n_rd); end
        checks++; if (wr_bad !== 0) begin errors++; $display("FAIL small_byte_data got %0d want 0", wr_bad); end
    endtask

    task automatic test_start_held();
        while (held < 20000) begin @(negedge clk); held++; end
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_done !== 1) begin errors++; $display("FAIL held_done_count got %0d want 1", n_done); end
        checks++; if (erase_q.size() !== 2) begin errors++; $display("FAIL held_erase_count got %0d want 2", erase_q.size()); end
        checks++; if (erase_q[1] !== 24'hFF_F000) begin errors++; $display("FAIL held_restart_addr got %h want fff000", erase_q[1]); end
        checks++; if (busy_w[2] !== 1'b1) begin errors++; $display("FAIL held_second_busy got %b want 1", busy_w[2]); end
        checks++; if (n_err !== 0) begin errors++; $display("FAIL held_error_count got %0d want 0", n_err); end
        checks++; if (ram_bad !== 0 || wr_bad !== 0) begin
            errors++; $display("FAIL held_data got ram_bad=%0d wr_bad=%0d want 0", ram_bad, wr_bad);
        end
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_save();
        test_reset_mid_page();
        test_timeout();
        test_small_size();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pac_flash_writer.md
PAC_FLASH_WRITER -- requirements
Module: pac_flash_writer

Interface
REQ-001 SHALL have parameter SRC_ADDR, default 24'h77_E000, SD-RAM start address of the PAC image.
REQ-002 SHALL have parameter DST_ADDR, default 24'h1F_0000, flash start address; multiple of 4096.
REQ-003 SHALL have parameter SIZE, default 24'h00_2000, bytes to save; nonzero multiple of 4096.
REQ-004 SHALL have parameter TIMEOUT, default 24'hFF_FFFF, maximum cycles to wait for FLASH_ACK or FLASH_DONE.
REQ-005 SHALL have port CLK  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-007 SHALL have port START  input  1  save request; sampled only in IDLE.
REQ-008 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse on successful completion.
REQ-010 SHALL have port ERROR  output  1  one-cycle pulse on timeout abort.
REQ-011 SHALL have port RAM_ADDR  output  24  SD-RAM byte read address.
REQ-012 SHALL have port RAM_REQ  output  1  read request, held until RAM_ACK.
REQ-013 SHALL have port RAM_ACK  input  1  read complete; RAM_RDATA valid this cycle.
REQ-014 SHALL have port RAM_RDATA  input  8  read data.
REQ-015 SHALL have port FLASH_REQ  output  1  flash operation request, held until FLASH_ACK.
REQ-016 SHALL have port FLASH_OP  output  1  0 = 4 KB sector erase, 1 = 256-byte page program.
REQ-017 SHALL have port FLASH_ADDR  output  24  sector or page base address.
REQ-018 SHALL have port FLASH_ACK  input  1  operation accepted.
REQ-019 SHALL have port FLASH_WDATA  output  8  program data byte.
REQ-020 SHALL have port FLASH_WVALID  output  1  FLASH_WDATA valid.
REQ-021 SHALL have port FLASH_WREADY  input  1  byte consumed when high together with FLASH_WVALID.
REQ-022 SHALL have port FLASH_DONE  input  1  one-cycle pulse when the erase or program operation has finished.

Function
REQ-023 SHALL have states IDLE, ERASE_REQ, ERASE_WAIT, PROG_REQ, RAM_RD, FL_WR, PROG_WAIT, FINISH.
REQ-024 SHALL, in IDLE with START=1, clear byte offset OFS (24 bit) to 0 and enter ERASE_REQ on the next cycle.
REQ-025 SHALL, in ERASE_REQ, drive FLASH_REQ=1, FLASH_OP=0, FLASH_ADDR=DST_ADDR+OFS; on FLASH_ACK go to ERASE_WAIT.
REQ-026 SHALL, in ERASE_WAIT on FLASH_DONE, add 4096 to OFS; if OFS+4096==SIZE, clear OFS and enter PROG_REQ, else re-enter ERASE_REQ.
REQ-027 SHALL, in PROG_REQ, drive FLASH_REQ=1, FLASH_OP=1, FLASH_ADDR=DST_ADDR+OFS (OFS[7:0]=0); on FLASH_ACK go to RAM_RD.
REQ-028 SHALL, in RAM_RD, drive RAM_REQ=1, RAM_ADDR=SRC_ADDR+OFS; on RAM_ACK latch RAM_RDATA into FLASH_WDATA and go to FL_WR.
REQ-029 SHALL, in FL_WR, drive FLASH_WVALID=1 with FLASH_WDATA held stable; on FLASH_WREADY increment OFS by 1, then go to PROG_WAIT if the new OFS[7:0]==0, else to RAM_RD.
REQ-030 SHALL, in PROG_WAIT on FLASH_DONE, enter FINISH if OFS==SIZE, else PROG_REQ.
REQ-031 SHALL, in FINISH, pulse DONE for exactly one cycle and return to IDLE.
REQ-032 SHALL keep RAM_REQ, FLASH_REQ, and FLASH_WVALID low outside their respective states, and drop each in the cycle after its ACK or WREADY.
REQ-033 SHALL count cycles in ERASE_REQ, ERASE_WAIT, PROG_REQ, and PROG_WAIT; the count SHALL clear on every state change; reaching TIMEOUT SHALL pulse ERROR, deassert all requests, and return to IDLE without DONE.
REQ-034 SHALL ignore START while BUSY=1; SHALL ignore FLASH_DONE, FLASH_ACK, and RAM_ACK in states not awaiting them.
REQ-035 SHALL compute all address sums modulo 2^24; DST_ADDR+SIZE crossing 24'hFF_FFFF wraps silently.
REQ-036 SHALL, with a single-cycle-response controller and RAM, take exactly 4 cycles per byte (RAM_RD, FL_WR) plus 3 cycles of page overhead.

Reset
REQ-037 SHALL, on RESET=1, enter IDLE on the next edge with BUSY=0, DONE=0, ERROR=0, RAM_REQ=0, FLASH_REQ=0, FLASH_WVALID=0, FLASH_OP=0, RAM_ADDR=0, FLASH_ADDR=0, FLASH_WDATA=0, OFS=0, timeout count=0.
REQ-038 SHALL give RESET priority over START and any in-flight handshake, including mid-page; the partial page is abandoned.

Verification
REQ-039 SHALL pass this test: default parameters, START pulse, ideal models -> erases at 1F_0000 and 1F_1000, then 32 programs 1F_0000..1F_1F00, 8192 RAM reads 77_E000..77_FFFF in order, flash bytes equal RAM bytes, one DONE pulse.
REQ-040 SHALL pass this test: FLASH_WREADY low 5 cycles on byte 0x7F -> FLASH_WDATA and FLASH_WVALID are stable throughout, no extra RAM read, byte written once.
REQ-041 SHALL pass this test: FLASH_DONE withheld after the 2nd erase, TIMEOUT=100 -> ERROR pulse 100 cycles into ERASE_WAIT, BUSY=0, no DONE, no program request.
REQ-042 SHALL pass this test: RESET asserted in FL_WR of page 5 -> the next cycle shows all requests low and BUSY=0; a new START restarts from an erase at DST_ADDR.
REQ-043 SHALL pass this test: START held high for 20000 cycles -> exactly one save sequence per IDLE entry; a second START while BUSY causes no disturbance.
REQ-044 SHALL pass this test: SIZE=4096, DST_ADDR=24'hFF_F000 -> one erase at FF_F000, 16 programs FF_F000..FF_FF00, DONE.
